demux4_stream: RTL and testbench

//  Routes one valid/ready data stream to one of four registered output streams by a 2-bit select.

---
 rtl/demux4_stream_if.sv | 23 ++
 rtl/demux4_stream.sv | 110 +++++++++++
 tb/tb_demux4_stream.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one valid/ready input stream and four valid/ready output streams.
// The slave modport is the demultiplexer's view; master is the producer/consumer side.
interface demux4_stream_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream: routes one valid/ready stream to one of four single-entry registered output slots.
// Optional feature macro: DEMUX4_STATS_EN adds per-output 16-bit accept counters on port xfer_count.
module demux4_stream #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  demux4_stream_if.slave  s
`ifdef DEMUX4_STATS_EN
  ,
  output logic [4*16-1:0] xfer_count
`endif
);

  logic [3:0]       out_valid_q;
  logic [3:0]       out_valid_d;
  logic [WIDTH-1:0] slot_data_q [4];
  logic [WIDTH-1:0] slot_data_d [4];
  logic [3:0]       slot_free;
  logic [3:0]       load;
  logic             in_ready;
  logic             accept;

  // A slot being drained this cycle can take a new beat, giving full rate per output.
  always_comb begin
    slot_free = ~out_valid_q | s.out_ready;
  end

  assign in_ready = reset_n & ~flush & slot_free[s.in_sel];
  assign accept   = s.in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[s.in_sel] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    for (int i = 0; i < 4; i++) begin
      slot_data_d[i] = slot_data_q[i];
      if (flush) begin
        out_valid_d[i] = 1'b0;
      end else if (load[i]) begin
        out_valid_d[i] = 1'b1;
        slot_data_d[i] = s.in_data;
      end else if (s.out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int i = 0; i < 4; i++) begin
        slot_data_q[i] <= slot_data_d[i];
      end
    end
  end

  always_comb begin
    s.out_data = '0;
    for (int i = 0; i < 4; i++) begin
      s.out_data[i*WIDTH +: WIDTH] = slot_data_q[i];
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.in_ready  = in_ready;

`ifdef DEMUX4_STATS_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  // Counters survive flush and wrap naturally at 16 bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i] + {15'd0, load[i]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    xfer_count = '0;
    for (int i = 0; i < 4; i++) begin
      xfer_count[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed scenarios plus randomized traffic
// checked against a per-output queue model of the stream.
module tb_demux4_stream;
  localparam int W = 32;

  logic clk;
  logic reset_n;
  logic flush;

  demux4_stream_if #(.WIDTH(W)) bus ();

`ifdef DEMUX4_STATS_EN
  logic [4*16-1:0] xfer_count;
`endif

  demux4_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .s          (bus)
`ifdef DEMUX4_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: beats waiting at each output, oldest first, plus accept counts.
  logic [W-1:0] mq [4][$];
  logic [15:0]  cnt [4];

  logic [3:0]   obs_valid;
  logic         obs_ready;
  logic [W-1:0] obs_data [4];
  logic [3:0]   exp_valid;
  logic         exp_ready;
  logic [W-1:0] exp_front [4];

  task automatic model_clear(input bit clear_cnt);
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      if (clear_cnt) cnt[i] = 16'd0;
    end
  endtask

  // Drive one cycle of stimulus, sample at negedge, advance model past the next posedge.
  task automatic drive_cycle(input logic v, input logic [1:0] sel, input logic [W-1:0] d,
                             input logic [3:0] rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = rdy;
    flush         = fl;
    @(negedge clk);
    obs_valid = bus.out_valid;
    obs_ready = bus.in_ready;
    for (int i = 0; i < 4; i++) begin
      obs_data[i]  = bus.out_data[i*W +: W];
      exp_valid[i] = (mq[i].size() > 0);
      exp_front[i] = (mq[i].size() > 0) ? mq[i][0] : '0;
    end
    exp_ready = !fl && ((mq[sel].size() == 0) || rdy[sel]);
    if (fl) begin
      model_clear(1'b0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() > 0 && rdy[i]) void'(mq[i].pop_front());
      end
      if (v && exp_ready) begin
        mq[sel].push_back(d);
        cnt[sel] = cnt[sel] + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'b0000;
    flush = 1'b0; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    model_clear(1'b1);
    drive_cycle(1'b1, 2'd1, 32'hDEAD_0001, 4'b0000, 1'b0);
    drive_cycle(1'b1, 2'd2, 32'hDEAD_0002, 4'b0000, 1'b0);
    bus.in_valid = 1'b1; bus.in_sel = 2'd3;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data);
    end
`ifdef DEMUX4_STATS_EN
    checks++;
    if (xfer_count !== '0) begin
      errors++; $display("FAIL reset_xfer_count: got %h want 0", xfer_count);
    end
`endif
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    model_clear(1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.in_sel = k[1:0];
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_release_ready sel=%0d: got %b want 1", k, bus.in_ready);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_route();
    logic [3:0]   ev [6];
    logic [W-1:0] ed [6];
    ev = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    ed = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive_cycle(1'b1, c[1:0], 32'hA0 + c, 4'b1111, 1'b0);
      else       drive_cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0);
      checks++;
      if (obs_valid !== ev[c]) begin
        errors++; $display("FAIL route_valid c=%0d: got %b want %b", c, obs_valid, ev[c]);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (obs_data[c-1] !== ed[c]) begin
          errors++; $display("FAIL route_data c=%0d: got %h want %h", c, obs_data[c-1], ed[c]);
        end
      end
      if (c < 4) begin
        checks++;
        if (obs_ready !== 1'b1) begin
          errors++; $display("FAIL route_ready c=%0d: got %b want 1", c, obs_ready);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic         vv [7];
    logic [1:0]   ss [7];
    logic [W-1:0] dd [7];
    logic [3:0]   rr [7];
    logic         er [7];
    logic [3:0]   ev [7];
    vv = '{1, 1, 1, 1, 1, 0, 0};
    ss = '{2, 2, 1, 2, 2, 0, 0};
    dd = '{32'h11, 32'h22, 32'h33, 32'h22, 32'h22, 32'h0, 32'h0};
    rr = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1111};
    er = '{1, 0, 1, 0, 1, 1, 1};
    ev = '{4'b0000, 4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0100, 4'b0000};
    for (int c = 0; c < 7; c++) begin
      drive_cycle(vv[c], ss[c], dd[c], rr[c], 1'b0);
      checks++;
      if (obs_valid !== ev[c]) begin
        errors++; $display("FAIL bp_valid c=%0d: got %b want %b", c, obs_valid, ev[c]);
      end
      if (vv[c]) begin
        checks++;
        if (obs_ready !== er[c]) begin
          errors++; $display("FAIL bp_ready c=%0d: got %b want %b", c, obs_ready, er[c]);
        end
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (obs_data[2] !== 32'h11) begin
          errors++; $display("FAIL bp_hold c=%0d: got %h want 00000011", c, obs_data[2]);
        end
      end
    end
    checks++;
    if (obs_data[2] !== 32'h22) begin
      errors++; $display("FAIL bp_second: got %h want 00000022", obs_data[2]);
    end
  endtask

  task automatic test_full_rate();
    for (int c = 0; c < 12; c++) begin
      if (c < 10) drive_cycle(1'b1, 2'd0, 32'h100 + c, 4'b1111, 1'b0);
      else        drive_cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0);
      if (c < 10) begin
        checks++;
        if (obs_ready !== 1'b1) begin
          errors++; $display("FAIL full_rate_ready c=%0d: got %b want 1", c, obs_ready);
        end
      end
      if (c >= 1 && c <= 10) begin
        checks++;
        if (obs_valid !== 4'b0001 || obs_data[0] !== 32'h100 + c - 1) begin
          errors++;
          $display("FAIL full_rate_beat c=%0d: got v=%b d=%h want v=0001 d=%h",
                   c, obs_valid, obs_data[0], 32'h100 + c - 1);
        end
      end
    end
    checks++;
    if (obs_valid !== 4'b0000) begin
      errors++; $display("FAIL full_rate_tail: got %b want 0000", obs_valid);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 2'd0, 32'h55, 4'b0000, 1'b0);
    drive_cycle(1'b1, 2'd3, 32'h66, 4'b0000, 1'b0);
    drive_cycle(1'b1, 2'd1, 32'h77, 4'b0000, 1'b1);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", obs_ready);
    end
    checks++;
    if (obs_valid !== 4'b1001) begin
      errors++; $display("FAIL flush_before: got %b want 1001", obs_valid);
    end
    drive_cycle(1'b0, 2'd0, '0, 4'b0000, 1'b0);
    checks++;
    if (obs_valid !== 4'b0000) begin
      errors++; $display("FAIL flush_after: got %b want 0000", obs_valid);
    end
  endtask

  task automatic test_random();
    logic         v;
    logic [1:0]   sel;
    logic [W-1:0] d;
    logic [3:0]   rdy;
    logic         fl;
    for (int c = 0; c < 2000; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      sel = 2'($urandom_range(0, 3));
      d   = $urandom;
      rdy = 4'($urandom);
      fl  = ($urandom_range(0, 31) == 0);
      drive_cycle(v, sel, d, rdy, fl);
      checks++;
      if (obs_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid c=%0d: got %b want %b", c, obs_valid, exp_valid);
      end
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready c=%0d: got %b want %b", c, obs_ready, exp_ready);
      end
      for (int i = 0; i < 4; i++) begin
        if (exp_valid[i]) begin
          checks++;
          if (obs_data[i] !== exp_front[i]) begin
            errors++;
            $display("FAIL rand_data c=%0d out=%0d: got %h want %h", c, i, obs_data[i], exp_front[i]);
          end
        end
      end
    end
    drive_cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0);
    drive_cycle(1'b0, 2'd0, '0, 4'b1111, 1'b0);
  endtask

`ifdef DEMUX4_STATS_EN
  task automatic test_stats();
    int n;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (xfer_count[i*16 +: 16] !== cnt[i]) begin
        errors++; $display("FAIL stats_count out=%0d: got %h want %h", i, xfer_count[i*16 +: 16], cnt[i]);
      end
    end
    n = 32'hFFFF - int'(cnt[1]);
    for (int k = 0; k < n; k++) drive_cycle(1'b1, 2'd1, $urandom, 4'b1111, 1'b0);
    checks++;
    if (xfer_count[16 +: 16] !== 16'hFFFF) begin
      errors++; $display("FAIL stats_preload: got %h want ffff", xfer_count[16 +: 16]);
    end
    drive_cycle(1'b1, 2'd1, 32'h1234, 4'b1111, 1'b0);
    checks++;
    if (xfer_count[16 +: 16] !== 16'h0000) begin
      errors++; $display("FAIL stats_wrap: got %h want 0000", xfer_count[16 +: 16]);
    end
    for (int i = 0; i < 4; i++) begin
      if (i != 1) begin
        checks++;
        if (xfer_count[i*16 +: 16] !== cnt[i]) begin
          errors++; $display("FAIL stats_other out=%0d: got %h want %h", i, xfer_count[i*16 +: 16], cnt[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    model_clear(1'b1);
    test_reset();
    test_route();
    test_backpressure();
    test_full_rate();
    test_flush();
    test_random();
`ifdef DEMUX4_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
